// File: rtl/param_sync_fifo.sv
// Parametrised synchronous FIFO: circular buffer with registered pop data, occupancy
// count, threshold flags and sticky overflow/underflow errors; 1-cycle read latency.
module param_sync_fifo #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH           = 8,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       VALID,
  input  logic                       WRITE,
  input  logic                       READ,
  input  logic [DATA_WIDTH-1:0]      DATA_IN,
  output logic [DATA_WIDTH-1:0]      DATA_OUT,
  output logic                       DATA_OUT_VALID,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ALMOST_FULL,
  output logic                       ALMOST_EMPTY,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;

  logic                  push_ok;
  logic                  pop_ok;
  logic                  push_drop;
  logic                  pop_miss;
  logic [CW-1:0]         count_nxt;

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    pop_ok    = VALID & READ & ~EMPTY;
    push_ok   = VALID & WRITE & (~FULL | pop_ok);
    push_drop = VALID & WRITE & FULL & ~pop_ok;
    pop_miss  = VALID & READ & EMPTY;
  end

  always_comb begin
    count_nxt = COUNT;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = COUNT + CW'(1);
      2'b01:   count_nxt = COUNT - CW'(1);
      default: count_nxt = COUNT;
    endcase
  end

  // Storage is never cleared; stale entries are unreachable once the pointers reset.
  always_ff @(posedge CLK) begin
    if (!RESET && push_ok) begin
      mem[wptr] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA_OUT       <= '0;
      DATA_OUT_VALID <= 1'b0;
    end else begin
      DATA_OUT_VALID <= pop_ok;
      if (pop_ok) DATA_OUT <= mem[rptr];
    end
  end

  // Flags come from the next count so they line up with COUNT after the edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      COUNT        <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
    end else begin
      COUNT        <= count_nxt;
      FULL         <= (count_nxt == DEPTH_C);
      EMPTY        <= (count_nxt == '0);
      ALMOST_FULL  <= (count_nxt >= AF_TH);
      ALMOST_EMPTY <= (count_nxt <= AE_TH);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (push_drop) OVERFLOW  <= 1'b1;
      if (pop_miss)  UNDERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives an 8x8 and a 16x16 FIFO with shared stimulus; queue-based models predict
// state, and per-DUT monitors score popped data against expected-output queues.
module tb_param_sync_fifo;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        VALID;
  logic        WRITE;
  logic        READ;
  logic [15:0] din;

  always #5 CLK = ~CLK;

  logic [7:0]  dout0;
  logic        dov0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [3:0]  cnt0;
  logic [15:0] dout1;
  logic        dov1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]  cnt1;

  param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)) dut0 (
    .CLK(CLK), .RESET(RESET), .VALID(VALID), .WRITE(WRITE), .READ(READ),
    .DATA_IN(din[7:0]), .DATA_OUT(dout0), .DATA_OUT_VALID(dov0), .COUNT(cnt0),
    .FULL(full0), .EMPTY(empty0), .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0),
    .OVERFLOW(ovf0), .UNDERFLOW(unf0));

  param_sync_fifo #(.DATA_WIDTH(16), .DEPTH(16), .ALMOST_FULL_TH(12), .ALMOST_EMPTY_TH(3)) dut1 (
    .CLK(CLK), .RESET(RESET), .VALID(VALID), .WRITE(WRITE), .READ(READ),
    .DATA_IN(din), .DATA_OUT(dout1), .DATA_OUT_VALID(dov1), .COUNT(cnt1),
    .FULL(full1), .EMPTY(empty1), .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1),
    .OVERFLOW(ovf1), .UNDERFLOW(unf1));

  int errors = 0;
  int checks = 0;

  // Reference state: stored data as plain queues plus sticky error bits.
  logic [15:0] mq0[$], mq1[$];
  logic [15:0] eq0[$], eq1[$];
  int          mdep[2]  = '{8, 16};
  int          maf[2]   = '{6, 12};
  int          mae[2]   = '{2, 3};
  logic [15:0] mmask[2] = '{16'h00FF, 16'hFFFF};
  bit          movf[2], munf[2], mvld[2];
  logic [15:0] mdout[2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit rst, input bit v, input bit w,
                            input bit r, input logic [15:0] d);
    int          sz;
    bit          pop_ok, push_ok;
    logic [15:0] val;
    sz = (k == 0) ? mq0.size() : mq1.size();
    if (rst) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      movf[k] = 0; munf[k] = 0; mvld[k] = 0; mdout[k] = 16'h0;
      return;
    end
    pop_ok  = v && r && (sz > 0);
    push_ok = v && w && ((sz < mdep[k]) || pop_ok);
    if (v && w && sz == mdep[k] && !pop_ok) movf[k] = 1;
    if (v && r && sz == 0) munf[k] = 1;
    mvld[k] = pop_ok;
    if (pop_ok) begin
      if (k == 0) begin val = mq0.pop_front(); eq0.push_back(val); end
      else        begin val = mq1.pop_front(); eq1.push_back(val); end
      mdout[k] = val;
    end
    if (push_ok) begin
      if (k == 0) mq0.push_back(d & mmask[0]); else mq1.push_back(d & mmask[1]);
    end
  endtask

  task automatic check_dut(input int k);
    int   sz;
    logic [31:0] c, f, e, a, b, o, u, dv, dd;
    string p;
    sz = (k == 0) ? mq0.size() : mq1.size();
    p  = (k == 0) ? "d0" : "d1";
    if (k == 0) begin
      c = 32'(cnt0); f = 32'(full0); e = 32'(empty0); a = 32'(af0); b = 32'(ae0);
      o = 32'(ovf0); u = 32'(unf0); dv = 32'(dov0); dd = 32'(dout0);
    end else begin
      c = 32'(cnt1); f = 32'(full1); e = 32'(empty1); a = 32'(af1); b = 32'(ae1);
      o = 32'(ovf1); u = 32'(unf1); dv = 32'(dov1); dd = 32'(dout1);
    end
    chk({p, ".count"},     c,  32'(sz));
    chk({p, ".full"},      f,  32'(sz == mdep[k]));
    chk({p, ".empty"},     e,  32'(sz == 0));
    chk({p, ".afull"},     a,  32'(sz >= maf[k]));
    chk({p, ".aempty"},    b,  32'(sz <= mae[k]));
    chk({p, ".overflow"},  o,  32'(movf[k]));
    chk({p, ".underflow"}, u,  32'(munf[k]));
    chk({p, ".dout_vld"},  dv, 32'(mvld[k]));
    chk({p, ".dout_hold"}, dd, 32'(mdout[k]));
  endtask

  task automatic step(input bit rst, input bit v, input bit w, input bit r,
                      input logic [15:0] d);
    RESET = rst; VALID = v; WRITE = w; READ = r; din = d;
    model_step(0, rst, v, w, r, d);
    model_step(1, rst, v, w, r, d);
    @(posedge CLK);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic push(input logic [15:0] d); step(0, 1, 1, 0, d); endtask
  task automatic pop();                      step(0, 1, 0, 1, 16'h0); endtask
  task automatic both(input logic [15:0] d); step(0, 1, 1, 1, d); endtask
  task automatic idle();                     step(0, 0, 0, 0, 16'h0); endtask

  // Scoreboard monitors: every DATA_OUT_VALID pulse must match the next expected word.
  always @(negedge CLK) begin
    if (dov0 === 1'b1) begin
      checks++;
      if (eq0.size() == 0) begin
        errors++;
        $display("FAIL d0.sb: unexpected pop data %0h", dout0);
      end else begin
        logic [15:0] x;
        x = eq0.pop_front();
        if (16'(dout0) !== x) begin
          errors++;
          $display("FAIL d0.sb: got %0h expected %0h at %0t", dout0, x, $time);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (dov1 === 1'b1) begin
      checks++;
      if (eq1.size() == 0) begin
        errors++;
        $display("FAIL d1.sb: unexpected pop data %0h", dout1);
      end else begin
        logic [15:0] x;
        x = eq1.pop_front();
        if (dout1 !== x) begin
          errors++;
          $display("FAIL d1.sb: got %0h expected %0h at %0t", dout1, x, $time);
        end
      end
    end
  end

  initial begin
    RESET = 1'b1; VALID = 1'b0; WRITE = 1'b0; READ = 1'b0; din = 16'h0;
    step(1, 0, 0, 0, 16'h0);
    step(1, 1, 1, 1, 16'h55);
    idle(); idle();

    // Fill with 0x11..0x88 then drain in order.
    for (int i = 1; i <= 8; i++) push(16'(i * 16'h11));
    for (int i = 0; i < 8; i++) pop();
    idle();

    // Pointer wrap.
    for (int i = 0; i < 5; i++) push(16'(16'h30 + i));
    for (int i = 0; i < 5; i++) pop();
    for (int i = 0; i < 6; i++) push(16'(16'hA0 + i));
    for (int i = 0; i < 6; i++) pop();

    // Overflow on the small FIFO, then underflow on both.
    for (int i = 0; i < 8; i++) push(16'(16'h60 + i));
    push(16'h00FF);
    both(16'h0077);
    for (int i = 0; i < 16; i++) pop();
    pop();

    // Simultaneous push+pop at count 3 and at count 0.
    for (int i = 0; i < 3; i++) push(16'(16'hC0 + i));
    both(16'h00C8); both(16'h00C9);
    for (int i = 0; i < 3; i++) pop();
    both(16'h00D0);
    pop();

    // VALID low masks requests; reset discards queued data.
    for (int i = 0; i < 5; i++) push(16'(16'hE0 + i));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 16'hBEEF);
    step(1, 1, 1, 1, 16'h1234);
    push(16'h0042);
    pop();
    idle();

    // Randomised phases: write-heavy, read-heavy, balanced, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      int ph;
      bit v, w, r, rst;
      ph  = (i / 150) % 3;
      v   = ($urandom_range(0, 9) != 0);
      w   = (ph == 0) ? ($urandom_range(0, 9) < 8) : (ph == 1) ? ($urandom_range(0, 9) < 2)
                                                               : ($urandom_range(0, 1) == 1);
      r   = (ph == 1) ? ($urandom_range(0, 9) < 8) : (ph == 0) ? ($urandom_range(0, 9) < 3)
                                                               : ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 599) == 0);
      step(rst, v, w, r, 16'($urandom));
    end

    idle();
    @(negedge CLK);
    chk("d0.sb_drained", 32'(eq0.size()), 32'd0);
    chk("d1.sb_drained", 32'(eq1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised synchronous FIFO, successor to the team's fixed 8x8 buffer. Configurable data width and depth, true circular-buffer ordering (first in, first out), full/empty/almost flags, occupancy count, and overflow/underflow error flags. Sits between protocol-layer stages that need elastic buffering with a Valid-qualified push/pop interface.

Parameters:
DATA_WIDTH, 8, bits per entry
DEPTH, 8, number of entries; power of 2, >= 2
ALMOST_FULL_TH, 6, ALMOST_FULL asserted when COUNT >= this value
ALMOST_EMPTY_TH, 2, ALMOST_EMPTY asserted when COUNT <= this value

Ports:
CLK  in  1  clock, all logic on rising edge
RESET  in  1  synchronous, active-high
VALID  in  1  global qualifier; WRITE/READ ignored when 0
WRITE  in  1  push request
READ  in  1  pop request
DATA_IN  in  DATA_WIDTH  push data
DATA_OUT  out  DATA_WIDTH  popped data, registered
DATA_OUT_VALID  out  1  1-cycle pulse: DATA_OUT updated this cycle
COUNT  out  log2(DEPTH)+1  entries currently stored
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
ALMOST_FULL  out  1  COUNT >= ALMOST_FULL_TH
ALMOST_EMPTY  out  1  COUNT <= ALMOST_EMPTY_TH
OVERFLOW  out  1  sticky: push attempted while FULL
UNDERFLOW  out  1  sticky: pop attempted while EMPTY

Behaviour:
- Reset (RESET=1 at posedge): write ptr = read ptr = 0, COUNT=0, DATA_OUT=0, DATA_OUT_VALID=0, OVERFLOW=UNDERFLOW=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0. RESET overrides all other inputs in the same cycle. Memory contents are not cleared.
- Effective push: push_ok = VALID & WRITE & (!FULL | pop_ok). Effective pop: pop_ok = VALID & READ & !EMPTY.
- Push writes DATA_IN to mem[wptr]; wptr increments modulo DEPTH. Pointers are log2(DEPTH) bits and wrap naturally.
- Pop: DATA_OUT <= mem[rptr] at the same edge; rptr increments modulo DEPTH; DATA_OUT_VALID=1 for that cycle. Latency is 1 clock from the READ edge to DATA_OUT.
- DATA_OUT holds its last value when no pop occurs. DATA_OUT_VALID is 0 on every cycle without pop_ok.
- COUNT update: +1 on push only, -1 on pop only, unchanged on both or neither.
- All flags are registered and derived from the next COUNT, so they are valid in the cycle after the edge that changes COUNT.
- Simultaneous push+pop when EMPTY: push only; no pop, UNDERFLOW set. No fall-through.
- Simultaneous push+pop when FULL: both occur; COUNT stays DEPTH; no OVERFLOW.
- Push when FULL without pop: data is dropped, pointers unchanged, OVERFLOW <= 1.
- Pop when EMPTY: DATA_OUT unchanged, DATA_OUT_VALID=0, UNDERFLOW <= 1.
- OVERFLOW/UNDERFLOW clear only on RESET.
- VALID=0: no state change apart from DATA_OUT_VALID dropping to 0.
- RESET mid-operation: all queued data is discarded (COUNT=0). The first push after reset is the first pop out.

Test Plan:
- Reset then idle -> EMPTY=1, FULL=0, COUNT=0, DATA_OUT=0, no error flags.
- Push 0x11..0x88 (8 writes) -> FULL=1, COUNT=8, ALMOST_FULL=1 from COUNT=6. Then 8 pops -> DATA_OUT 0x11..0x88 in order, each 1 cycle after READ, EMPTY=1 at end.
- Wrap: push 5, pop 5, push 6 (0xA0..0xA5), pop 6 -> order 0xA0..0xA5 preserved across pointer wrap.
- Full + push 0xFF without read -> OVERFLOW=1, COUNT=8; subsequent pops do not return 0xFF. Empty + READ -> UNDERFLOW=1, DATA_OUT_VALID=0.
- Simultaneous WRITE+READ at COUNT=8 and at COUNT=3 -> COUNT unchanged, output order correct. At COUNT=0 -> COUNT=1, UNDERFLOW=1.
- VALID=0 with WRITE=READ=1 for 4 cycles -> no change. RESET asserted at COUNT=5 -> COUNT=0, EMPTY=1, flags cleared. Run with DATA_WIDTH=16, DEPTH=16 as well.
